// File: rtl/gamma_pkg.sv
// Shared definitions for the gamma-cycle scheduler: controller states and
// width helpers for the spike-pulse arithmetic.
package gamma_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } state_e;

    // Time-field width for a gamma cycle of g aclk cycles.
    function automatic int timeWidth(input int g);
        return $clog2(g);
    endfunction

    // Width that holds t + pw without wrap-around for any t of tw bits.
    function automatic int endWidth(input int tw, input int pw);
        return tw + $clog2(pw) + 1;
    endfunction

endpackage

// File: rtl/spike_enc.sv
// Pulse-width spike encoder for one temporal input: high while the phase
// lies in [t, t+PW), clipped to the gamma cycle by the caller's run enable.
module spike_enc
    import gamma_pkg::*;
#(
    parameter int G  = 16,
    parameter int PW = 8,
    parameter int TW = 4
) (
    input  logic [TW-1:0] p_i,
    input  logic [TW-1:0] t_i,
    input  logic          mask_i,
    input  logic          run_i,
    output logic          spk_o
);

    localparam int EW = endWidth(TW, PW);

    logic [EW-1:0] pExt;
    logic [EW-1:0] tExt;
    logic [EW-1:0] tEnd;
    logic          inCycle;

    // Widened so t+PW never wraps back below p near the end of the cycle.
    assign pExt    = EW'(p_i);
    assign tExt    = EW'(t_i);
    assign tEnd    = tExt + EW'(PW);
    assign inCycle = (tExt < EW'(G));

    assign spk_o = run_i & mask_i & inCycle & (pExt >= tExt) & (pExt < tEnd);

endmodule

// File: rtl/gamma_sched.sv
// Gamma-cycle job scheduler: encodes latched spike times as pulses for one
// gamma cycle and reports the phase at which the datapath result first rises.
module gamma_sched
    import gamma_pkg::*;
#(
    parameter int N_IN              = 2,
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    localparam int TW               = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic              aclk,
    input  logic              grst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN*TW-1:0] in_times,
    input  logic [N_IN-1:0]   in_mask,
    output logic [N_IN-1:0]   spk_out,
    output logic              dp_rst,
    input  logic              res_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TW-1:0]     out_time,
    output logic              out_none,
    output logic              busy
);

    localparam logic [TW-1:0] LAST_PHASE = TW'(GAMMA_CYCLE_WIDTH - 1);

    state_e              state_q,   state_d;
    logic [TW-1:0]       phase_q,   phase_d;
    logic [N_IN*TW-1:0]  times_q,   times_d;
    logic [N_IN-1:0]     mask_q,    mask_d;
    logic [TW-1:0]       capTime_q, capTime_d;
    logic                capHit_q,  capHit_d;
    logic [TW-1:0]       outTime_q, outTime_d;
    logic                outNone_q, outNone_d;
    logic                runEn;

    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            times_q   <= '0;
            mask_q    <= '0;
            capTime_q <= '0;
            capHit_q  <= 1'b0;
            outTime_q <= '0;
            outNone_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            times_q   <= times_d;
            mask_q    <= mask_d;
            capTime_q <= capTime_d;
            capHit_q  <= capHit_d;
            outTime_q <= outTime_d;
            outNone_q <= outNone_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        times_d   = times_q;
        mask_d    = mask_q;
        capTime_d = capTime_q;
        capHit_d  = capHit_q;
        outTime_d = outTime_q;
        outNone_d = outNone_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    times_d = in_times;
                    mask_d  = in_mask;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                phase_d   = '0;
                capTime_d = '0;
                capHit_d  = 1'b0;
                state_d   = RUN;
            end
            RUN: begin
                if (res_in && !capHit_q) begin
                    capHit_d  = 1'b1;
                    capTime_d = phase_q;
                end
                // Result registers load from the next-state capture so a
                // first rise on the final phase is still reported.
                if (phase_q == LAST_PHASE) begin
                    outTime_d = capHit_d ? capTime_d : '0;
                    outNone_d = ~capHit_d;
                    state_d   = REPORT;
                end else begin
                    phase_d = phase_q + TW'(1);
                end
            end
            REPORT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign runEn     = (state_q == RUN);
    assign in_ready  = (state_q == IDLE);
    assign dp_rst    = (state_q == CLEAR);
    assign out_valid = (state_q == REPORT);
    assign busy      = (state_q != IDLE);
    assign out_time  = outTime_q;
    assign out_none  = outNone_q;

    for (genvar i = 0; i < N_IN; i++) begin : gEnc
        spike_enc #(
            .G  (GAMMA_CYCLE_WIDTH),
            .PW (PULSE_WIDTH),
            .TW (TW)
        ) uEnc (
            .p_i    (phase_q),
            .t_i    (times_q[i*TW +: TW]),
            .mask_i (mask_q[i]),
            .run_i  (runEn),
            .spk_o  (spk_out[i])
        );
    end

endmodule
